spi_bus_arbiter: RTL and testbench

Arbitrates the single board SPI bus (SCK, MOSI, MISO and the active-low slave selects for OLED, uSD, DES, APP, VS_xCS and VS_xDCS) among several SPI masters, such as the CPU SPI_1 core and a hardware stream engine. It sits between the masters and the pad-level SPI signals in the top level. Each master requests the bus and receives an exclusive grant. Round-robin fairness, a release guard time and an optional idle-hold timeout prevent one master from locking out the others.

---
 rtl/spi_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Shares one board SPI bus between several masters: round-robin grant, forced-idle
// guard after each release, and optional revocation of a master that holds the bus idle.
module spi_bus_arbiter #(
  parameter int   REQ_CNT      = 2,
  parameter int   SS_CNT       = 6,
  parameter int   GUARD_CYCLES = 4,
  parameter int   HOLD_TIMEOUT = 0,
  parameter logic SCK_IDLE     = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REQ_CNT-1:0]        req_i,
  output logic [REQ_CNT-1:0]        gnt_o,
  input  logic [REQ_CNT-1:0]        sck_i,
  input  logic [REQ_CNT-1:0]        mosi_i,
  input  logic [REQ_CNT*SS_CNT-1:0] ss_i,
  input  logic                      miso_i,
  output logic                      sck_o,
  output logic                      mosi_o,
  output logic [SS_CNT-1:0]         ss_o,
  output logic [REQ_CNT-1:0]        miso_o,
  output logic [1:0]                owner_o,
  output logic                      busy_o
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int HW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;

  state_t              state, state_nxt;
  logic [1:0]          ptr, ptr_nxt, owner_nxt;
  logic [REQ_CNT-1:0]  gnt_nxt;
  logic                sck_nxt, mosi_nxt;
  logic [SS_CNT-1:0]   ss_nxt;
  logic [GW-1:0]       guard_cnt, guard_nxt;
  logic [HW-1:0]       idle_cnt, idle_nxt;

  logic                own_req, own_sck, own_mosi;
  logic [SS_CNT-1:0]   own_ss;
  logic                win_vld;
  logic [1:0]          win;
  logic                others_req, revoke;

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    own_req  = 1'b0;
    own_sck  = SCK_IDLE;
    own_mosi = 1'b1;
    own_ss   = '1;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (owner_o == 2'(k)) begin
        own_req  = req_i[k];
        own_sck  = sck_i[k];
        own_mosi = mosi_i[k];
        own_ss   = ss_i[k*SS_CNT +: SS_CNT];
      end
    end
  end

  // First requester found searching upward from ptr, wrapping at REQ_CNT.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr;
    for (int i = 0; i < REQ_CNT; i++) begin
      for (int k = 0; k < REQ_CNT; k++) begin
        if (!win_vld && k == (int'(ptr) + i) % REQ_CNT && req_i[k]) begin
          win_vld = 1'b1;
          win     = 2'(k);
        end
      end
    end
  end

  assign others_req = |(req_i & ~gnt_o);
  assign revoke     = (HOLD_TIMEOUT != 0) && (idle_cnt == HOLD_LIMIT) && others_req;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_o;
    owner_nxt = owner_o;
    ptr_nxt   = ptr;
    sck_nxt   = SCK_IDLE;
    mosi_nxt  = 1'b1;
    ss_nxt    = '1;
    guard_nxt = '0;
    idle_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_nxt = S_GRANT;
          owner_nxt = win;
          for (int k = 0; k < REQ_CNT; k++) gnt_nxt[k] = (win == 2'(k));
        end
      end
      S_GRANT: begin
        if (!own_req || revoke) begin
          state_nxt = S_GUARD;
          gnt_nxt   = '0;
          ptr_nxt   = (owner_o == 2'(REQ_CNT - 1)) ? 2'd0 : owner_o + 2'd1;
        end else begin
          sck_nxt  = own_sck;
          mosi_nxt = own_mosi;
          ss_nxt   = own_ss;
          // Saturates at the limit so a late second requester still triggers revocation.
          if (&own_ss) idle_nxt = (idle_cnt == HOLD_LIMIT) ? idle_cnt : idle_cnt + 1'b1;
        end
      end
      S_GUARD: begin
        if (guard_cnt == GUARD_LAST) state_nxt = S_IDLE;
        else                         guard_nxt = guard_cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      gnt_o     <= '0;
      owner_o   <= '0;
      ptr       <= '0;
      sck_o     <= SCK_IDLE;
      mosi_o    <= 1'b1;
      ss_o      <= '1;
      busy_o    <= 1'b0;
      guard_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt_o     <= gnt_nxt;
      owner_o   <= owner_nxt;
      ptr       <= ptr_nxt;
      sck_o     <= sck_nxt;
      mosi_o    <= mosi_nxt;
      ss_o      <= ss_nxt;
      busy_o    <= (state_nxt != S_IDLE);
      guard_cnt <= guard_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  always_comb begin
    miso_o = '1;
    if (state == S_GRANT) begin
      for (int k = 0; k < REQ_CNT; k++) begin
        if (owner_o == 2'(k)) miso_o[k] = miso_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: stimulus queues edge-stamped expectations,
// a monitor compares them against the outputs 1 ns after the matching clock edge.
module tb_spi_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req   = 2'b00;
  logic [1:0]  sck   = 2'b00;
  logic [1:0]  mosi  = 2'b11;
  logic [11:0] ss    = '1;
  logic        miso_i = 1'b0;

  logic [1:0]  gnt_o, miso_o, owner_o;
  logic        sck_o, mosi_o, busy_o;
  logic [5:0]  ss_o;

  spi_bus_arbiter #(
    .REQ_CNT(2), .SS_CNT(6), .GUARD_CYCLES(4), .HOLD_TIMEOUT(16), .SCK_IDLE(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .gnt_o(gnt_o),
    .sck_i(sck), .mosi_i(mosi), .ss_i(ss), .miso_i(miso_i),
    .sck_o(sck_o), .mosi_o(mosi_o), .ss_o(ss_o), .miso_o(miso_o),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {K_GNT, K_PIN, K_MISO} kind_t;
  typedef struct {
    int          at;
    kind_t       kind;
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (edge %0d)", name, act, want, edge_n);
    end
  endtask

  function automatic logic [15:0] actual(input kind_t k);
    case (k)
      K_GNT:   return {11'd0, busy_o, owner_o, gnt_o};
      K_PIN:   return {8'd0, ss_o, sck_o, mosi_o};
      default: return {14'd0, miso_o};
    endcase
  endfunction

  function automatic void expect_at(input int at, input kind_t k, input string nm,
                                    input logic [15:0] v);
    exp_t e;
    e.at = at; e.kind = k; e.name = nm; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void exp_gnt(input int at, input string nm, input logic [1:0] g,
                                  input logic [1:0] o, input logic b);
    expect_at(at, K_GNT, nm, {11'd0, b, o, g});
  endfunction

  function automatic void exp_pin(input int at, input string nm, input logic [5:0] s,
                                  input logic c, input logic m);
    expect_at(at, K_PIN, nm, {8'd0, s, c, m});
  endfunction

  function automatic void exp_miso(input int at, input string nm, input logic [1:0] m);
    expect_at(at, K_MISO, nm, {14'd0, m});
  endfunction

  // Monitor: edge_n counts rising edges; expectations stamped with that edge are checked here.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      edge_n++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == edge_n) begin
          check(sb[i].name, actual(sb[i].kind), sb[i].val);
          sb.delete(i);
        end else if (sb[i].at < edge_n) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: slot at edge %0d skipped", sb[i].name, sb[i].at);
          sb.delete(i);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, g;
    logic [1:0] own_bit;

    // Reset held for three edges.
    step(2);
    exp_gnt(3, "rst_gnt", 2'b00, 2'd0, 1'b0);
    exp_pin(3, "rst_pin", 6'h3F, 1'b0, 1'b1);
    exp_miso(3, "rst_miso", 2'b11);
    step(1);
    rst_i = 1'b0;

    // Simultaneous requests after reset: master 0 first, master 1 after the guard.
    t = edge_n;
    req = 2'b11; ss = {6'h3B, 6'h3E}; sck = 2'b10; mosi = 2'b01; miso_i = 1'b0;
    exp_gnt(t + 1, "simul_gnt0", 2'b01, 2'd0, 1'b1);
    exp_miso(t + 1, "simul_miso0", 2'b10);
    exp_pin(t + 2, "simul_pin0", 6'h3E, 1'b0, 1'b1);
    exp_gnt(t + 3, "simul_rel", 2'b00, 2'd0, 1'b1);
    exp_pin(t + 3, "simul_rel_pin", 6'h3F, 1'b0, 1'b1);
    exp_miso(t + 3, "guard_miso", 2'b11);
    exp_pin(t + 5, "guard_pin_a", 6'h3F, 1'b0, 1'b1);
    exp_pin(t + 7, "guard_pin_b", 6'h3F, 1'b0, 1'b1);
    exp_gnt(t + 7, "guard_busy", 2'b00, 2'd0, 1'b1);
    exp_gnt(t + 8, "guard_done", 2'b00, 2'd0, 1'b0);
    exp_gnt(t + 9, "simul_gnt1", 2'b10, 2'd1, 1'b1);
    exp_miso(t + 9, "simul_miso1", 2'b01);
    exp_pin(t + 10, "simul_pin1", 6'h3B, 1'b1, 1'b0);
    exp_gnt(t + 11, "simul_rel1", 2'b00, 2'd1, 1'b1);
    step(2);
    req = 2'b10;
    step(8);
    req = 2'b00;
    step(6);

    // Round robin: both masters keep re-requesting; owners must alternate.
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      g = edge_n + 1;
      own_bit = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_gnt(g, "rr_gnt", own_bit, 2'(i % 2), 1'b1);
      exp_gnt(g + 2, "rr_rel", 2'b00, 2'(i % 2), 1'b1);
      step(2);
      req = req & ~own_bit;
      step(1);
      req = req | own_bit;
      step(5);
    end
    req = 2'b00;
    exp_gnt(edge_n + 1, "rr_none", 2'b00, 2'd1, 1'b0);
    step(1);

    // Single master with pin lag, MISO routing and a forced release while selects are low.
    t = edge_n;
    req = 2'b01; sck[0] = 1'b1; mosi[0] = 1'b0; ss[5:0] = 6'h3D; miso_i = 1'b0;
    exp_gnt(t + 1, "single_gnt", 2'b01, 2'd0, 1'b1);
    exp_pin(t + 1, "single_pin_lag", 6'h3F, 1'b0, 1'b1);
    exp_miso(t + 1, "single_miso0", 2'b10);
    exp_pin(t + 2, "single_pin_a", 6'h3D, 1'b1, 1'b0);
    step(2);
    sck[0] = 1'b0; mosi[0] = 1'b1; miso_i = 1'b1;
    exp_pin(t + 3, "single_pin_b", 6'h3D, 1'b0, 1'b1);
    exp_miso(t + 3, "single_miso1", 2'b11);
    step(1);
    req[0] = 1'b0; ss[5:0] = 6'h00; miso_i = 1'b0;
    exp_gnt(t + 4, "forced_rel", 2'b00, 2'd0, 1'b1);
    exp_pin(t + 4, "forced_pin", 6'h3F, 1'b0, 1'b1);
    exp_miso(t + 4, "forced_miso", 2'b11);
    exp_pin(t + 5, "forced_pin2", 6'h3F, 1'b0, 1'b1);
    step(1);
    ss[5:0] = '1;
    step(5);

    // Hold timeout: a low select after 9 idle cycles restarts the count; revoke at 16.
    t = edge_n;
    g = t + 1;
    req = 2'b01;
    exp_gnt(g, "hold_gnt0", 2'b01, 2'd0, 1'b1);
    step(1);
    req = 2'b11;
    step(9);
    ss[5:0] = 6'h3E;
    exp_pin(g + 10, "hold_sel_low", 6'h3E, 1'b0, 1'b1);
    step(1);
    ss[5:0] = '1;
    exp_gnt(g + 17, "hold_restart", 2'b01, 2'd0, 1'b1);
    exp_gnt(g + 26, "hold_pre", 2'b01, 2'd0, 1'b1);
    exp_gnt(g + 27, "hold_revoke", 2'b00, 2'd0, 1'b1);
    exp_gnt(g + 32, "hold_idle", 2'b00, 2'd0, 1'b0);
    exp_gnt(g + 33, "hold_gnt1", 2'b10, 2'd1, 1'b1);
    step(23);
    req = 2'b10; ss[11:6] = '1;
    exp_gnt(g + 52, "no_revoke_a", 2'b10, 2'd1, 1'b1);
    step(20);
    ss[11:6] = 6'h3E;
    exp_gnt(g + 54, "no_revoke_b", 2'b10, 2'd1, 1'b1);
    exp_pin(g + 54, "mid_pin", 6'h3E, 1'b1, 1'b0);

    // Reset mid-transfer, then the pending master 0 wins because the pointer returned to 0.
    step(1);
    rst_i = 1'b1; req = 2'b11;
    exp_gnt(g + 55, "rst_mid_gnt", 2'b00, 2'd0, 1'b0);
    exp_pin(g + 55, "rst_mid_pin", 6'h3F, 1'b0, 1'b1);
    exp_miso(g + 55, "rst_mid_miso", 2'b11);
    step(1);
    rst_i = 1'b0;
    exp_gnt(g + 56, "rst_regrant", 2'b01, 2'd0, 1'b1);
    step(1);
    req = 2'b00;
    step(8);

    while (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for edge %0d never checked", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
